// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : add_pipe
//  Description : Chunked, carry-pipelined adder/subtractor with optional
//                signed saturation and valid/ready flow control.
//                The DW-bit addition is split into STAGES chunks of
//                DW/STAGES bits. Stage k adds chunk k using the carry that
//                stage k-1 registered on the previous edge. Operands are
//                skewed forward so each chunk arrives with its carry. Result
//                chunks are de-skewed so the whole sum leaves together.
//                STAGES must be >= 1 and DW must be a multiple of STAGES.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                in_valid / in_ready   - operand handshake
//                a, b, opt_sub, cin    - operands, subtract select, carry/borrow in
//                opt_sat               - clamp signed overflow
//                out_valid / out_ready - result handshake
//                sum, cout             - result, raw MSB carry-out
//                zero, neg             - flags of the driven (post-clamp) sum
//                overflow, sat         - raw signed overflow, clamp applied
//  Revision    : 1.0 - initial release
// ============================================================================
module add_pipe #(
    parameter int DW     = 32,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          opt_sub,
    input  logic          cin,
    input  logic          opt_sat,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] sum,
    output logic          cout,
    output logic          zero,
    output logic          neg,
    output logic          overflow,
    output logic          sat
);

    localparam int            c_cw      = DW / STAGES;
    localparam logic [DW-1:0] c_sat_max = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] c_sat_min = {1'b1, {(DW-1){1'b0}}};

    // Subtraction is a + ~b + !cin, so a borrow-in becomes a missing carry.
    logic [DW-1:0] w_be;
    logic          w_c0;
    logic          w_adv;

    assign w_be = b ^ {DW{opt_sub}};
    assign w_c0 = cin ^ opt_sub;

    // Output register state.
    logic          r_out_valid;
    logic [DW-1:0] r_sum;
    logic          r_cout;
    logic          r_zero;
    logic          r_neg;
    logic          r_ovf;
    logic          r_sat;

    // Every stage moves in lock-step, so a stall at the output freezes all.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // Inputs of the final stage: its operand chunk, incoming carry, the
    // lower result bits already in final position, and transaction tags.
    logic [c_cw-1:0] w_fin_a;
    logic [c_cw-1:0] w_fin_be;
    logic            w_fin_c;
    logic            w_fin_v;
    logic            w_fin_s;
    logic [DW-1:0]   w_fin_low;

    if (STAGES == 1) begin : g_single
        assign w_fin_a   = a[c_cw-1:0];
        assign w_fin_be  = w_be[c_cw-1:0];
        assign w_fin_c   = w_c0;
        assign w_fin_v   = in_valid;
        assign w_fin_s   = opt_sat;
        assign w_fin_low = '0;
    end else begin : g_multi
        localparam int c_nr = STAGES - 1;

        // Rank j registers. r_a/r_be hold the not-yet-added operand bits
        // shifted down so the next chunk always sits at bits [c_cw-1:0];
        // this also carries a[DW-1] and be[DW-1] to the final stage.
        // r_res holds the finished low chunks in their final bit positions.
        logic          r_v   [c_nr];
        logic          r_c   [c_nr];
        logic          r_s   [c_nr];
        logic [DW-1:0] r_a   [c_nr];
        logic [DW-1:0] r_be  [c_nr];
        logic [DW-1:0] r_res [c_nr];

        logic          w_src_v   [c_nr];
        logic          w_src_c   [c_nr];
        logic          w_src_s   [c_nr];
        logic [DW-1:0] w_src_a   [c_nr];
        logic [DW-1:0] w_src_be  [c_nr];
        logic [DW-1:0] w_src_res [c_nr];
        logic [c_cw:0] w_add     [c_nr];

        always_comb begin
            w_src_v[0]   = in_valid;
            w_src_c[0]   = w_c0;
            w_src_s[0]   = opt_sat;
            w_src_a[0]   = a;
            w_src_be[0]  = w_be;
            w_src_res[0] = '0;
            for (int j = 1; j < c_nr; j++) begin
                w_src_v[j]   = r_v[j-1];
                w_src_c[j]   = r_c[j-1];
                w_src_s[j]   = r_s[j-1];
                w_src_a[j]   = r_a[j-1];
                w_src_be[j]  = r_be[j-1];
                w_src_res[j] = r_res[j-1];
            end
            for (int j = 0; j < c_nr; j++) begin
                w_add[j] = {1'b0, w_src_a[j][c_cw-1:0]}
                         + {1'b0, w_src_be[j][c_cw-1:0]}
                         + {{c_cw{1'b0}}, w_src_c[j]};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j < c_nr; j++) begin
                    r_v[j] <= 1'b0;
                end
            end else if (w_adv) begin
                for (int j = 0; j < c_nr; j++) begin
                    r_v[j]   <= w_src_v[j];
                    r_c[j]   <= w_add[j][c_cw];
                    r_s[j]   <= w_src_s[j];
                    r_a[j]   <= w_src_a[j] >> c_cw;
                    r_be[j]  <= w_src_be[j] >> c_cw;
                    r_res[j] <= w_src_res[j]
                              | (DW'(w_add[j][c_cw-1:0]) << (j * c_cw));
                end
            end
        end

        assign w_fin_a   = r_a[c_nr-1][c_cw-1:0];
        assign w_fin_be  = r_be[c_nr-1][c_cw-1:0];
        assign w_fin_c   = r_c[c_nr-1];
        assign w_fin_v   = r_v[c_nr-1];
        assign w_fin_s   = r_s[c_nr-1];
        assign w_fin_low = r_res[c_nr-1];
    end

    // Final stage: top chunk, overflow detection and clamping.
    logic [c_cw:0] w_fin_add;
    logic [DW-1:0] w_raw;
    logic          w_ovf;
    logic          w_sat;
    logic [DW-1:0] w_sum;

    assign w_fin_add = {1'b0, w_fin_a} + {1'b0, w_fin_be} + {{c_cw{1'b0}}, w_fin_c};
    assign w_raw     = w_fin_low | (DW'(w_fin_add[c_cw-1:0]) << (DW - c_cw));
    // Top bits of the final operand chunks are a[DW-1] and be[DW-1].
    assign w_ovf     = (w_fin_a[c_cw-1] == w_fin_be[c_cw-1])
                    && (w_raw[DW-1] != w_fin_a[c_cw-1]);
    assign w_sat     = w_fin_s && w_ovf;
    assign w_sum     = w_sat ? (w_fin_a[c_cw-1] ? c_sat_min : c_sat_max) : w_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_sat       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_fin_v;
            r_sum       <= w_sum;
            r_cout      <= w_fin_add[c_cw];
            r_zero      <= (w_sum == '0);
            r_neg       <= w_sum[DW-1];
            r_ovf       <= w_ovf;
            r_sat       <= w_sat;
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign overflow  = r_ovf;
    assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_pipe
//  Description : Self-checking bench for add_pipe (DW=8, STAGES=2). Results
//                are predicted by an integer-arithmetic reference model and
//                compared in order against the DUT output stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_pipe;

    localparam int DW     = 8;
    localparam int STAGES = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          opt_sub;
    logic          cin;
    logic          opt_sat;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sum;
    logic          cout;
    logic          zero;
    logic          neg;
    logic          overflow;
    logic          sat;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       zero;
        logic       neg;
        logic       ovf;
        logic       sat;
    } res_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       s;
        logic       st;
        res_t       e;
    } dvec_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    add_pipe #(.DW(DW), .STAGES(STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .opt_sub  (opt_sub),
        .cin      (cin),
        .opt_sat  (opt_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .zero     (zero),
        .neg      (neg),
        .overflow (overflow),
        .sat      (sat)
    );

    // Reference: exact integer arithmetic, unsigned for carry, signed for
    // overflow, then clamp.
    function automatic res_t model(input logic [7:0] fa, input logic [7:0] fb,
                                   input logic fc, input logic fs, input logic fsat);
        res_t r;
        int ua, ub, sa, sb, ci, full, sres;
        ua = int'(fa);
        ub = int'(fb);
        sa = int'($signed(fa));
        sb = int'($signed(fb));
        ci = fc ? 1 : 0;
        if (fs) begin
            full   = ua - ub - ci;
            sres   = sa - sb - ci;
            r.cout = (full >= 0);
        end else begin
            full   = ua + ub + ci;
            sres   = sa + sb + ci;
            r.cout = (full > 255);
        end
        r.ovf = (sres > 127) || (sres < -128);
        r.sat = fsat && r.ovf;
        if (r.sat) r.sum = (sres > 127) ? 8'h7F : 8'h80;
        else       r.sum = full[7:0];
        r.zero = (r.sum == 8'h00);
        r.neg  = r.sum[7];
        return r;
    endfunction

    function automatic res_t observed();
        return {sum, cout, zero, neg, overflow, sat};
    endfunction

    task automatic drive_rand();
        a       = 8'($urandom);
        b       = 8'($urandom);
        cin     = 1'($urandom_range(0, 1));
        opt_sub = 1'($urandom_range(0, 1));
        opt_sat = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; opt_sub = 1'b0; opt_sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        n_vec++;
        if (observed() !== res_t'(0)) begin
            n_err++; $display("FAIL reset_outputs got=%h exp=0", observed());
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        dvec_t tab [9];
        tab[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}};
        tab[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}};
        tab[2] = '{8'h05, 8'h05, 1'b0, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
        tab[3] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
        tab[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 1'b1, '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}};
        tab[5] = '{8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
        tab[6] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
        tab[7] = '{8'h10, 8'h01, 1'b1, 1'b1, 1'b0, '{8'h0E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
        tab[8] = '{8'h80, 8'hFF, 1'b0, 1'b0, 1'b1, '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}};
        for (int i = 0; i < 9; i++) begin
            a = tab[i].a; b = tab[i].b; cin = tab[i].c;
            opt_sub = tab[i].s; opt_sat = tab[i].st;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_early_valid got=%b exp=0", i, out_valid);
            end
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_err++; $display("FAIL dir%0d_latency got=%b exp=1", i, out_valid);
            end
            n_vec++;
            if (observed() !== tab[i].e) begin
                n_err++; $display("FAIL dir%0d_result got=%h exp=%h", i, observed(), tab[i].e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        exp_q.delete();
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                drive_rand();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_in_ready cyc%0d got=%b exp=1", i, in_ready);
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, opt_sub, opt_sat));
            n_vec++;
            if (out_valid !== (i >= 2)) begin
                n_err++; $display("FAIL b2b_valid cyc%0d got=%b exp=%b", i, out_valid, (i >= 2));
            end
            if (out_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra got=%h exp=none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin
                        n_err++; $display("FAIL b2b_result cyc%0d got=%h exp=%h", i, observed(), e);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL b2b_lost got=%0d pending exp=0", exp_q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        res_t e;
        int   k;
        logic acc;
        exp_q.delete();
        out_ready = 1'b0;
        for (k = 0; k < 10; k++) begin
            drive_rand();
            in_valid = 1'b1;
            #1;
            if (out_valid && !in_ready) break;
            if (in_ready) exp_q.push_back(model(a, b, cin, opt_sub, opt_sat));
            @(posedge clk); #1;
        end
        n_vec++;
        if (k >= 10 || exp_q.size() != STAGES) begin
            n_err++; $display("FAIL bp_fill got=%0d queued exp=%0d", exp_q.size(), STAGES);
        end
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold%0d got rdy=%b vld=%b exp rdy=0 vld=1", h, in_ready, out_valid);
            end
            n_vec++;
            if (exp_q.size() == 0 || observed() !== exp_q[0]) begin
                n_err++; $display("FAIL bp_frozen%0d got=%h exp=%h", h, observed(),
                                  (exp_q.size() != 0) ? exp_q[0] : res_t'(0));
            end
        end
        acc = 1'b0;
        for (k = 0; k < 20 && (exp_q.size() != 0 || in_valid); k++) begin
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, opt_sub, opt_sat));
                acc = 1'b1;
            end
            if (out_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra got=%h exp=none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin
                        n_err++; $display("FAIL bp_result got=%h exp=%h", observed(), e);
                    end
                end
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            acc = 1'b0;
        end
        n_vec++;
        if (exp_q.size() != 0 || in_valid) begin
            n_err++; $display("FAIL bp_drain got=%0d pending exp=0", exp_q.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_rand();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || observed() !== res_t'(0)) begin
            n_err++; $display("FAIL rstmid_clear got vld=%b out=%h exp vld=0 out=0", out_valid, observed());
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready);
        end
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL rstmid_stale cyc%0d got=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_random_stall();
        res_t e;
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            drive_rand();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_vec++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_err++; $display("FAIL rnd_in_ready cyc%0d got=%b exp=%b", i, in_ready, (!out_valid || out_ready));
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, opt_sub, opt_sat));
            if (out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra got=%h exp=none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin
                        n_err++; $display("FAIL rnd_result cyc%0d got=%h exp=%h", i, observed(), e);
                    end
                end
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            #1;
            if (out_valid === 1'b1) begin
                n_vec++;
                e = exp_q.pop_front();
                if (observed() !== e) begin
                    n_err++; $display("FAIL rnd_drain got=%h exp=%h", observed(), e);
                end
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rnd_lost got=%0d pending exp=0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL provide parameter DW, default 32, data width in bits.
REQ-002 SHALL provide parameter STAGES, default 4, pipeline depth; legal when STAGES >= 1 and DW % STAGES == 0; chunk width CW = DW/STAGES.
REQ-003 SHALL provide port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL provide in_valid, input, 1, operand set present.
REQ-006 SHALL provide in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL provide a, input, DW, first operand.
REQ-008 SHALL provide b, input, DW, second operand.
REQ-009 SHALL provide opt_sub, input, 1, 1 = subtract (a - b - cin), 0 = add (a + b + cin).
REQ-010 SHALL provide cin, input, 1, carry-in for add; borrow-in for subtract.
REQ-011 SHALL provide opt_sat, input, 1, 1 = clamp signed overflow to signed max/min.
REQ-012 SHALL provide out_valid, output, 1, result present.
REQ-013 SHALL provide out_ready, input, 1, downstream accepts result.
REQ-014 SHALL provide sum, output, DW, result (saturated when applicable).
REQ-015 SHALL provide cout, output, 1, raw carry-out of MSB (subtract: 1 = no borrow).
REQ-016 SHALL provide zero, neg, overflow, sat, outputs, 1 each: sum==0; sum[DW-1]; raw signed overflow; clamping applied.

Function
REQ-017 SHALL compute effective operand be = b XOR {DW{opt_sub}} and LSB carry-in c0 = cin XOR opt_sub; raw = a + be + c0, DW+1 bits, cout = raw[DW].
REQ-018 SHALL split the addition into STAGES chunks; stage k adds bits [k*CW +: CW] using the registered carry from stage k-1; no stage holds an adder wider than CW+1 bits.
REQ-019 SHALL skew operands through per-stage registers so each chunk is added exactly when its carry arrives, and de-skew result chunks so all DW bits of sum present together.
REQ-020 SHALL carry opt_sat, a[DW-1], be[DW-1] with each transaction to the final stage.
REQ-021 SHALL compute overflow = (a[DW-1] == be[DW-1]) && (raw[DW-1] != a[DW-1]).
REQ-022 SHALL, when opt_sat=1 and overflow=1, drive sum = {0,1...1} if a[DW-1]=0 else {1,0...0}, sat=1; otherwise sum = raw[DW-1:0], sat=0.
REQ-023 SHALL derive zero and neg from the final driven sum (post-saturation); cout and overflow always reflect raw.
REQ-024 SHALL use a global advance enable adv = !out_valid || out_ready; all stages shift only when adv=1; in_ready = adv.
REQ-025 SHALL accept a transaction on a cycle with in_valid && in_ready, and present it with out_valid=1 exactly STAGES rising edges later when no stall occurs.
REQ-026 SHALL sustain one transaction per cycle with out_ready held 1; bubbles (in_valid=0) propagate as invalid slots.
REQ-027 SHALL, when out_valid=1 and out_ready=0, hold sum, cout and all flags stable and accept no input until released.
REQ-028 SHALL preserve transaction order; no transaction dropped or duplicated.
REQ-029 SHALL for STAGES=1 behave as a single registered full-width adder with latency 1.
REQ-030 SHALL treat outputs when out_valid=0 as don't-care apart from reset values.

Reset
REQ-031 SHALL, while reset=1 at a rising edge, clear all stage valid bits, out_valid=0, sum=0, cout=0, zero=0, neg=0, overflow=0, sat=0.
REQ-032 SHALL discard all in-flight transactions when reset asserts mid-operation; none emerge after release.
REQ-033 SHALL drive in_ready=1 during and after reset (pipeline empty).

Verification (DW=8, STAGES=2)
REQ-034 SHALL verify add: a=0x7F,b=0x01,cin=0,sub=0,sat=0 -> 2 cycles later sum=0x80,cout=0,overflow=1,neg=1,sat=0; same with sat=1 -> sum=0x7F,sat=1,neg=0,overflow=1.
REQ-035 SHALL verify subtract: 0x05-0x05,cin=0 -> sum=0x00,zero=1,cout=1; 0x00-0x01 -> sum=0xFF,cout=0,neg=1,overflow=0; 0x80-0x01,sat=1 -> sum=0x80,overflow=1,sat=1.
REQ-036 SHALL verify cross-chunk carry: 0x0F+0x01 -> 0x10; 0xFF+0x00,cin=1 -> sum=0x00,cout=1,zero=1.
REQ-037 SHALL verify throughput: 16 back-to-back random transactions, out_ready=1 -> 16 consecutive out_valid cycles, results in order matching a golden model.
REQ-038 SHALL verify backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs frozen; release -> all results delivered in order, none lost.
REQ-039 SHALL verify reset mid-operation: reset pulse with 2 transactions in flight -> out_valid=0 next cycle, no stale result emerges afterward.
